// File: rtl/io_port_pkg.sv
// Shared register offsets and the decoded register type for the io_port GPIO block.
package io_port_pkg;

  localparam logic [2:0] IOP_OUT   = 3'd0;
  localparam logic [2:0] IOP_DIR   = 3'd1;
  localparam logic [2:0] IOP_IN    = 3'd2;
  localparam logic [2:0] IOP_RISE  = 3'd3;
  localparam logic [2:0] IOP_FALL  = 3'd4;
  localparam logic [2:0] IOP_IRQEN = 3'd5;
  localparam logic [2:0] IOP_SET   = 3'd6;
  localparam logic [2:0] IOP_CLR   = 3'd7;

  typedef enum logic [2:0] {
    REG_OUT   = IOP_OUT,
    REG_DIR   = IOP_DIR,
    REG_IN    = IOP_IN,
    REG_RISE  = IOP_RISE,
    REG_FALL  = IOP_FALL,
    REG_IRQEN = IOP_IRQEN,
    REG_SET   = IOP_SET,
    REG_CLR   = IOP_CLR
  } iop_reg_e;

endpackage

// File: rtl/io_sync_edge.sv
// Two-flop pin synchroniser with a history flop; produces rise/fall pulses once armed.
module io_sync_edge #(
  parameter int WIDTH = 8
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic [WIDTH-1:0] i_Pins,
  output logic [WIDTH-1:0] o_Sync,
  output logic [WIDTH-1:0] o_Rise,
  output logic [WIDTH-1:0] o_Fall,
  output logic             o_Armed
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_prev;
  logic [1:0]       r_arm;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
      r_arm  <= 2'd0;
    end else begin
      r_s1   <= i_Pins;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      if (r_arm != 2'd3) r_arm <= r_arm + 2'd1;
    end
  end

  // Until the pipeline has refilled from reset, s2/prev differences are reset artefacts.
  assign o_Armed = (r_arm == 2'd3);
  assign o_Sync  = r_s2;
  assign o_Rise  = o_Armed ? (r_s2 & ~r_prev) : '0;
  assign o_Fall  = o_Armed ? (~r_s2 & r_prev) : '0;

endmodule

// File: rtl/io_port.sv
// Memory-mapped GPIO responder: output latch, direction, synchronised input,
// sticky edge flags with write-1-to-clear, and a registered interrupt.
module io_port
  import io_port_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int PORT_WIDTH = 8
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Select,
  input  logic [ADDR_WIDTH-1:0] i_Addr,
  input  logic                  i_WrEnable,
  input  logic [DATA_WIDTH-1:0] i_WrData,
  output logic [DATA_WIDTH-1:0] o_RdData,
  input  logic [PORT_WIDTH-1:0] i_Pins,
  output logic [PORT_WIDTH-1:0] o_PinsOut,
  output logic [PORT_WIDTH-1:0] o_PinsOe,
  output logic                  o_Irq
);

  logic [PORT_WIDTH-1:0] r_out;
  logic [PORT_WIDTH-1:0] r_dir;
  logic [PORT_WIDTH-1:0] r_rise;
  logic [PORT_WIDTH-1:0] r_fall;
  logic [PORT_WIDTH-1:0] r_irqen;
  logic                  r_irq;

  logic [PORT_WIDTH-1:0] w_sync;
  logic [PORT_WIDTH-1:0] w_rise;
  logic [PORT_WIDTH-1:0] w_fall;
  logic                  w_armed;
  logic                  w_wr;
  iop_reg_e              w_reg;
  logic [PORT_WIDTH-1:0] w_wdata;
  logic [PORT_WIDTH-1:0] w_rise_clr;
  logic [PORT_WIDTH-1:0] w_fall_clr;
  logic [PORT_WIDTH-1:0] w_rd_val;
  logic                  w_unused;

  io_sync_edge #(.WIDTH(PORT_WIDTH)) u_sync_edge (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Pins  (i_Pins),
    .o_Sync  (w_sync),
    .o_Rise  (w_rise),
    .o_Fall  (w_fall),
    .o_Armed (w_armed)
  );

  assign w_wr       = i_Select & i_WrEnable;
  assign w_reg      = iop_reg_e'(i_Addr[2:0]);
  assign w_wdata    = i_WrData[PORT_WIDTH-1:0];
  assign w_rise_clr = (w_wr && w_reg == REG_RISE) ? w_wdata : '0;
  assign w_fall_clr = (w_wr && w_reg == REG_FALL) ? w_wdata : '0;
  assign w_unused   = ^i_Addr ^ ^i_WrData ^ w_armed;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_out   <= '0;
      r_dir   <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      r_irqen <= '0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wr) begin
        case (w_reg)
          REG_OUT:   r_out   <= w_wdata;
          REG_DIR:   r_dir   <= w_wdata;
          REG_IRQEN: r_irqen <= w_wdata;
          REG_SET:   r_out   <= r_out | w_wdata;
          REG_CLR:   r_out   <= r_out & ~w_wdata;
          default:   ;
        endcase
      end
      // OR-ing the new edge after the clear makes a coincident edge win over W1C.
      r_rise <= (r_rise & ~w_rise_clr) | w_rise;
      r_fall <= (r_fall & ~w_fall_clr) | w_fall;
      r_irq  <= |((r_rise | r_fall) & r_irqen);
    end
  end

  always_comb begin
    w_rd_val = '0;
    case (w_reg)
      REG_OUT:   w_rd_val = r_out;
      REG_DIR:   w_rd_val = r_dir;
      REG_IN:    w_rd_val = w_sync;
      REG_RISE:  w_rd_val = r_rise;
      REG_FALL:  w_rd_val = r_fall;
      REG_IRQEN: w_rd_val = r_irqen;
      default:   w_rd_val = '0;
    endcase
  end

  always_comb begin
    o_RdData = '0;
    if (i_Select) o_RdData[PORT_WIDTH-1:0] = w_rd_val;
  end

  assign o_PinsOut = r_out;
  assign o_PinsOe  = r_dir;
  assign o_Irq     = r_irq;

endmodule

// File: tb/tb_io_port.sv
// Directed checks of the io_port register map, pin synchronisation timing, edge flags and IRQ.
module tb_io_port;

  logic        clk;
  logic        rst;
  logic        sel;
  logic [9:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  pins;
  logic [7:0]  pins_out;
  logic [7:0]  pins_oe;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  io_port dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_Select   (sel),
    .i_Addr     (addr),
    .i_WrEnable (we),
    .i_WrData   (wdata),
    .o_RdData   (rdata),
    .i_Pins     (pins),
    .o_PinsOut  (pins_out),
    .o_PinsOe   (pins_oe),
    .o_Irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers: write commits at the next rising edge; outputs are sampled 1 unit after it.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic s = 1'b1);
    @(negedge clk);
    sel = s; we = 1'b1; addr = {7'd0, a}; wdata = d;
    @(posedge clk);
    #1;
    sel = 1'b0; we = 1'b0; wdata = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = {7'd0, a};
    #1;
    d = rdata;
    sel = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    tick(n);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    do_reset(2);
    #1;
    checks++;
    if (pins_out !== 8'h00 || pins_oe !== 8'h00 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: out=%h oe=%h irq=%b, want 00 00 0", pins_out, pins_oe, irq);
    end
    for (int r = 0; r < 8; r++) begin
      bus_read(r[2:0], v);
      checks++;
      if (v !== 32'h0) begin
        failures++;
        $display("FAIL reset_reg%0d: got %h want 00000000", r, v);
      end
    end
  endtask

  task automatic test_out_dir;
    logic [31:0] v;
    bus_write(3'd0, 32'h0000_00A5);
    bus_write(3'd1, 32'hFFFF_FF0F);
    checks++;
    if (pins_out !== 8'hA5 || pins_oe !== 8'h0F) begin
      failures++;
      $display("FAIL out_dir_pins: out=%h oe=%h, want a5 0f", pins_out, pins_oe);
    end
    bus_read(3'd0, v);
    checks++;
    if (v !== 32'h0000_00A5) begin
      failures++;
      $display("FAIL read_out: got %h want 000000a5", v);
    end
    bus_read(3'd1, v);
    checks++;
    if (v !== 32'h0000_000F) begin
      failures++;
      $display("FAIL read_dir_upper_zero: got %h want 0000000f", v);
    end
  endtask

  task automatic test_set_clr;
    logic [31:0] v;
    bus_write(3'd6, 32'h10);
    bus_read(3'd0, v);
    checks++;
    if (v !== 32'hB5) begin
      failures++;
      $display("FAIL set: got %h want 000000b5", v);
    end
    bus_write(3'd7, 32'h01);
    bus_read(3'd0, v);
    checks++;
    if (v !== 32'hB4 || pins_out !== 8'hB4) begin
      failures++;
      $display("FAIL clr: got %h pins %h want b4", v, pins_out);
    end
    bus_read(3'd6, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL read_set_wo: got %h want 0", v);
    end
    bus_read(3'd7, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL read_clr_wo: got %h want 0", v);
    end
  endtask

  task automatic test_rise_irq;
    logic [31:0] v;
    bus_write(3'd5, 32'h01);
    @(negedge clk);
    pins = 8'h01;
    tick(1); // edge k
    bus_read(3'd2, v);
    checks++;
    if (v !== 32'h00) begin
      failures++;
      $display("FAIL in_early: got %h want 0 after edge k", v);
    end
    tick(1); // edge k+1
    bus_read(3'd2, v);
    checks++;
    if (v !== 32'h01) begin
      failures++;
      $display("FAIL in_k1: got %h want 01", v);
    end
    bus_read(3'd3, v);
    checks++;
    if (v !== 32'h00) begin
      failures++;
      $display("FAIL rise_k1: got %h want 0", v);
    end
    tick(1); // edge k+2
    bus_read(3'd3, v);
    checks++;
    if (v !== 32'h01 || irq !== 1'b0) begin
      failures++;
      $display("FAIL rise_k2: rise=%h irq=%b want 01 0", v, irq);
    end
    tick(1); // edge k+3
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_k3: got %b want 1", irq);
    end
    bus_write(3'd3, 32'h01);
    bus_read(3'd3, v);
    checks++;
    if (v !== 32'h00 || irq !== 1'b1) begin
      failures++;
      $display("FAIL w1c_rise: rise=%h irq=%b want 00 1", v, irq);
    end
    tick(1);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_drop: got %b want 0", irq);
    end
  endtask

  task automatic test_arming;
    logic [31:0] v;
    @(negedge clk);
    pins = 8'hFF;
    do_reset(2);
    tick(6);
    bus_read(3'd3, v);
    checks++;
    if (v !== 32'h00) begin
      failures++;
      $display("FAIL arm_rise: got %h want 00", v);
    end
    bus_read(3'd2, v);
    checks++;
    if (v !== 32'hFF) begin
      failures++;
      $display("FAIL arm_in: got %h want ff", v);
    end
  endtask

  task automatic test_w1c_collision;
    logic [31:0] v;
    @(negedge clk);
    pins = 8'hF7;
    tick(4);
    bus_read(3'd4, v);
    checks++;
    if (v !== 32'h08) begin
      failures++;
      $display("FAIL fall_set: got %h want 08", v);
    end
    bus_write(3'd4, 32'h08);
    bus_read(3'd4, v);
    checks++;
    if (v !== 32'h00) begin
      failures++;
      $display("FAIL fall_w1c: got %h want 00", v);
    end
    @(negedge clk);
    pins = 8'hFF;
    tick(4);
    bus_read(3'd3, v);
    checks++;
    if (v !== 32'h08) begin
      failures++;
      $display("FAIL rise_bit3: got %h want 08", v);
    end
    // Fall flag would set at edge k+2; the W1C below commits at that same edge.
    @(negedge clk);
    pins = 8'hF7;
    tick(2);
    bus_write(3'd4, 32'h08);
    bus_read(3'd4, v);
    checks++;
    if (v !== 32'h08) begin
      failures++;
      $display("FAIL set_wins: got %h want 08", v);
    end
  endtask

  task automatic test_deselect_and_reset;
    logic [31:0] v;
    bus_write(3'd0, 32'h5A, 1'b0);
    checks++;
    if (pins_out !== 8'h00) begin
      failures++;
      $display("FAIL deselect_write: out=%h want 00", pins_out);
    end
    addr = 10'd0;
    #1;
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL deselect_read: got %h want 0", rdata);
    end
    bus_write(3'd0, 32'hC3);
    bus_write(3'd5, 32'hFF);
    tick(1);
    checks++;
    if (irq !== 1'b1 || pins_out !== 8'hC3) begin
      failures++;
      $display("FAIL pre_reset: irq=%b out=%h want 1 c3", irq, pins_out);
    end
    @(negedge clk);
    rst = 1'b1;
    tick(1);
    checks++;
    if (irq !== 1'b0 || pins_out !== 8'h00 || pins_oe !== 8'h00) begin
      failures++;
      $display("FAIL midrun_reset: irq=%b out=%h oe=%h want 0 00 00", irq, pins_out, pins_oe);
    end
    for (int r = 3; r < 6; r++) begin
      bus_read(r[2:0], v);
      checks++;
      if (v !== 32'h0) begin
        failures++;
        $display("FAIL midrun_reg%0d: got %h want 0", r, v);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0; pins = 8'h00;
    test_reset();
    test_out_dir();
    test_set_clr();
    test_rise_irq();
    test_arming();
    test_w1c_collision();
    test_deselect_and_reset();
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
